// File: rtl/ppheavy_pulse_gen.sv
// Heavy-power gate pulse generator: turns on-timer start strobes into
// tick-timed heavy_on pulses with dead-time, pulse counting and overrun flagging.
module ppheavy_pulse_gen #(
  parameter int CW = 8,
  parameter int NW = 4
) (
  input  logic          clk_sys,
  input  logic          rst_n,
  input  logic          rst_state,
  input  logic          clk_10k,
  input  logic          start,
  input  logic [CW-1:0] on_width,
  input  logic [CW-1:0] dead_width,
  input  logic [NW-1:0] pulse_num,
  output logic          heavy_on,
  output logic          busy,
  output logic          done,
  output logic [NW-1:0] pulse_cnt,
  output logic          err_overrun
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    DEAD = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [NW-1:0] PULSE_ONE = NW'(1);
  localparam logic [NW-1:0] PULSE_MAX = '1;

  state_t        state, state_nx;
  logic          sync1, sync2, tick;
  logic [CW-1:0] tick_cnt, tick_cnt_nx;
  logic [CW-1:0] on_w, on_w_nx;
  logic [CW-1:0] dead_w, dead_w_nx;
  logic [NW-1:0] pulse_n, pulse_n_nx;
  logic [NW-1:0] pulse_cnt_nx, pulse_inc;
  logic          err_nx, heavy_nx, busy_nx, done_nx;

  // clk_10k is asynchronous; the edge detect yields one clk_sys cycle per rising edge
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= clk_10k;
      sync2 <= sync1;
    end
  end

  assign tick      = sync1 & ~sync2;
  assign pulse_inc = (pulse_cnt == PULSE_MAX) ? pulse_cnt : pulse_cnt + PULSE_ONE;

  always_comb begin
    state_nx     = state;
    tick_cnt_nx  = tick_cnt;
    on_w_nx      = on_w;
    dead_w_nx    = dead_w;
    pulse_n_nx   = pulse_n;
    pulse_cnt_nx = pulse_cnt;
    err_nx       = err_overrun;

    if (!rst_state) begin
      state_nx     = IDLE;
      tick_cnt_nx  = '0;
      on_w_nx      = '0;
      dead_w_nx    = '0;
      pulse_n_nx   = '0;
      pulse_cnt_nx = '0;
      err_nx       = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // A tick coinciding with the accepted start is deliberately dropped
          if (start) begin
            on_w_nx     = (on_width == '0) ? CNT_ONE : on_width;
            dead_w_nx   = dead_width;
            pulse_n_nx  = (pulse_num == '0) ? PULSE_ONE : pulse_num;
            tick_cnt_nx = '0;
            state_nx    = ON;
          end
        end
        ON: begin
          if (start) err_nx = 1'b1;
          if (tick) begin
            if (tick_cnt == on_w - CNT_ONE) begin
              tick_cnt_nx  = '0;
              pulse_cnt_nx = pulse_inc;
              if (pulse_inc == pulse_n)  state_nx = DONE;
              else if (dead_w == '0)     state_nx = IDLE;
              else                       state_nx = DEAD;
            end else begin
              tick_cnt_nx = tick_cnt + CNT_ONE;
            end
          end
        end
        DEAD: begin
          if (start) err_nx = 1'b1;
          if (tick) begin
            if (tick_cnt == dead_w - CNT_ONE) begin
              tick_cnt_nx = '0;
              state_nx    = IDLE;
            end else begin
              tick_cnt_nx = tick_cnt + CNT_ONE;
            end
          end
        end
        DONE: begin
          if (start) err_nx = 1'b1;
        end
        default: state_nx = IDLE;
      endcase
    end

    // Outputs are decoded from the next state so the registers line up with it
    heavy_nx = (state_nx == ON);
    busy_nx  = (state_nx == ON) || (state_nx == DEAD);
    done_nx  = (state_nx == DONE) && (state != DONE);
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      tick_cnt    <= '0;
      on_w        <= '0;
      dead_w      <= '0;
      pulse_n     <= '0;
      pulse_cnt   <= '0;
      err_overrun <= 1'b0;
      heavy_on    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state       <= state_nx;
      tick_cnt    <= tick_cnt_nx;
      on_w        <= on_w_nx;
      dead_w      <= dead_w_nx;
      pulse_n     <= pulse_n_nx;
      pulse_cnt   <= pulse_cnt_nx;
      err_overrun <= err_nx;
      heavy_on    <= heavy_nx;
      busy        <= busy_nx;
      done        <= done_nx;
    end
  end

endmodule

// File: tb/tb_ppheavy_pulse_gen.sv
// Directed bench for ppheavy_pulse_gen: drives clk_10k edges and start strobes
// by hand and checks pulse widths in ticks, counters, flags and resets.
module tb_ppheavy_pulse_gen;

  logic       clk_sys = 1'b0;
  logic       rst_n, rst_state, clk_10k, start;
  logic [7:0] on_width, dead_width;
  logic [3:0] pulse_num;
  logic       heavy_on, busy, done, err_overrun;
  logic [3:0] pulse_cnt;

  int tests = 0;
  int fails = 0;
  int done_cnt = 0;
  int rise_cnt = 0;
  int bad_done = 0;
  int done_base, rise_base;
  logic prev_heavy = 1'b0;
  logic prev_done  = 1'b0;

  ppheavy_pulse_gen #(.CW(8), .NW(4)) dut (
    .clk_sys    (clk_sys),
    .rst_n      (rst_n),
    .rst_state  (rst_state),
    .clk_10k    (clk_10k),
    .start      (start),
    .on_width   (on_width),
    .dead_width (dead_width),
    .pulse_num  (pulse_num),
    .heavy_on   (heavy_on),
    .busy       (busy),
    .done       (done),
    .pulse_cnt  (pulse_cnt),
    .err_overrun(err_overrun)
  );

  always #5 clk_sys = ~clk_sys;

  // done must be a single cycle coinciding with heavy_on falling
  always @(negedge clk_sys) begin
    if (heavy_on && !prev_heavy) rise_cnt <= rise_cnt + 1;
    if (done) begin
      done_cnt <= done_cnt + 1;
      if (!(prev_heavy && !heavy_on) || prev_done) bad_done <= bad_done + 1;
    end
    prev_heavy <= heavy_on;
    prev_done  <= done;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // mode 0: tick only; 1: start one cycle after the tick; 2: start with the tick
  task automatic applyStimulus(input int mode);
    @(negedge clk_sys);
    clk_10k = 1'b1;
    @(negedge clk_sys);
    if (mode == 2) start = 1'b1;
    @(negedge clk_sys);
    start = 1'b0;
    if (mode == 1) begin
      start = 1'b1;
      @(negedge clk_sys);
      start = 1'b0;
    end
    repeat (3) @(negedge clk_sys);
    clk_10k = 1'b0;
    repeat (4) @(negedge clk_sys);
  endtask

  task automatic pulse_rst_state();
    @(negedge clk_sys);
    rst_state = 1'b0;
    @(negedge clk_sys);
    rst_state = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; rst_state = 1'b1; clk_10k = 1'b0; start = 1'b0;
    on_width = 8'd0; dead_width = 8'd0; pulse_num = 4'd0;
    repeat (3) @(negedge clk_sys);
    rst_n = 1'b1;
    @(negedge clk_sys);
    checkOutput("rst_heavy", heavy_on, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_pcnt", pulse_cnt, 0);
    checkOutput("rst_err", err_overrun, 0);

    // Asynchronous reset in the middle of a second pulse with an overrun pending
    on_width = 8'd3; dead_width = 8'd0; pulse_num = 4'd4;
    applyStimulus(1);
    for (int i = 0; i < 3; i++) applyStimulus(0);
    checkOutput("ar_pcnt1", pulse_cnt, 1);
    applyStimulus(1);
    applyStimulus(1);
    checkOutput("ar_heavy_pre", heavy_on, 1);
    checkOutput("ar_err_pre", err_overrun, 1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("ar_heavy", heavy_on, 0);
    checkOutput("ar_busy", busy, 0);
    checkOutput("ar_pcnt", pulse_cnt, 0);
    checkOutput("ar_err", err_overrun, 0);
    @(negedge clk_sys);
    rst_n = 1'b1;

    // Basic sequence: two 5-tick pulses, 2-tick dead-time
    on_width = 8'd5; dead_width = 8'd2; pulse_num = 4'd2;
    done_base = done_cnt; rise_base = rise_cnt;
    for (int n = 1; n <= 40; n++) begin
      applyStimulus((n == 20 || n == 35) ? 1 : 0);
      checkOutput("basic_heavy", heavy_on, 32'((n >= 20 && n <= 24) || (n >= 35 && n <= 39)));
      if (n == 25) checkOutput("basic_pcnt1", pulse_cnt, 1);
      if (n == 26) checkOutput("basic_busy_dead", busy, 1);
      if (n == 27) checkOutput("basic_busy_idle", busy, 0);
    end
    checkOutput("basic_pcnt2", pulse_cnt, 2);
    checkOutput("basic_done", done_cnt - done_base, 1);
    checkOutput("basic_rises", rise_cnt - rise_base, 2);
    checkOutput("basic_err", err_overrun, 0);

    // Overrun: second start lands inside a 20-tick pulse
    pulse_rst_state();
    on_width = 8'd20; dead_width = 8'd0; pulse_num = 4'd2;
    done_base = done_cnt; rise_base = rise_cnt;
    for (int n = 1; n <= 40; n++) begin
      applyStimulus((n == 20 || n == 35) ? 1 : 0);
      checkOutput("ovr_heavy", heavy_on, 32'(n >= 20 && n <= 39));
      if (n == 35) checkOutput("ovr_err_set", err_overrun, 1);
    end
    checkOutput("ovr_err_held", err_overrun, 1);
    checkOutput("ovr_pcnt", pulse_cnt, 1);
    checkOutput("ovr_rises", rise_cnt - rise_base, 1);
    checkOutput("ovr_done", done_cnt - done_base, 0);

    // Zero widths and count: a single 1-tick pulse then DONE
    pulse_rst_state();
    checkOutput("zero_err_clr", err_overrun, 0);
    on_width = 8'd0; dead_width = 8'd0; pulse_num = 4'd0;
    done_base = done_cnt;
    applyStimulus(1);
    checkOutput("zero_heavy_on", heavy_on, 1);
    applyStimulus(0);
    checkOutput("zero_heavy_off", heavy_on, 0);
    checkOutput("zero_pcnt", pulse_cnt, 1);
    checkOutput("zero_done", done_cnt - done_base, 1);
    checkOutput("zero_busy", busy, 0);
    applyStimulus(1);
    checkOutput("zero_start_in_done", err_overrun, 1);
    checkOutput("zero_no_pulse", heavy_on, 0);
    checkOutput("zero_pcnt_held", pulse_cnt, 1);

    // rst_state while in DEAD, then a fresh full-width pulse
    pulse_rst_state();
    on_width = 8'd4; dead_width = 8'd5; pulse_num = 4'd3;
    applyStimulus(1);
    for (int i = 0; i < 4; i++) applyStimulus(0);
    checkOutput("dead_busy", busy, 1);
    checkOutput("dead_heavy", heavy_on, 0);
    checkOutput("dead_pcnt", pulse_cnt, 1);
    applyStimulus(1);
    checkOutput("dead_err", err_overrun, 1);
    pulse_rst_state();
    checkOutput("rs_busy", busy, 0);
    checkOutput("rs_pcnt", pulse_cnt, 0);
    checkOutput("rs_err", err_overrun, 0);
    rise_base = rise_cnt;
    applyStimulus(1);
    for (int n = 1; n <= 4; n++) begin
      applyStimulus(0);
      checkOutput("rs_fresh_heavy", heavy_on, 32'(n <= 3));
    end
    checkOutput("rs_fresh_pcnt", pulse_cnt, 1);
    checkOutput("rs_fresh_rises", rise_cnt - rise_base, 1);

    // Tick coinciding with start is not counted; on_width change mid-pulse ignored
    pulse_rst_state();
    on_width = 8'd3; dead_width = 8'd0; pulse_num = 4'd1;
    done_base = done_cnt;
    applyStimulus(2);
    checkOutput("sim_heavy_start", heavy_on, 1);
    on_width = 8'd10;
    for (int n = 1; n <= 3; n++) begin
      applyStimulus(0);
      checkOutput("sim_heavy", heavy_on, 32'(n <= 2));
    end
    checkOutput("sim_done", done_cnt - done_base, 1);
    checkOutput("sim_pcnt", pulse_cnt, 1);

    @(negedge clk_sys);
    checkOutput("done_shape", bad_done, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
